seg_scan_driver: RTL
====================

Name: seg_scan_driver

Overview:
Time-multiplexed driver for a NUM_DIGITS common-anode seven-segment display bank. It sits downstream of the BCD digit sources and replaces per-digit static decoders with one shared decoder. It buffers a packed BCD word, scans one digit at a time with a dwell/guard cadence to suppress ghosting, and drives the shared segment bus and the active-low anode enables.

Parameters:
NUM_DIGITS, 4, number of display digits (>=2)
DWELL_CYCLES, 50000, clk cycles each digit is lit (>=1)
GUARD_CYCLES, 1000, clk cycles of all-anodes-off between digits (0 = no guard)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  scan enable; low = display blanked
load  in  1  one-cycle strobe; capture bcd_in/dp_in into pending buffer
bcd_in  in  4*NUM_DIGITS  packed BCD; digit 0 = bits [3:0] = rightmost
dp_in  in  NUM_DIGITS  decimal-point request per digit
seg_out  out  7  segments a..g, MSB = a, 1 = lit
dp_out  out  1  decimal point, 1 = lit
an_n  out  NUM_DIGITS  anode enables, active low
digit_idx  out  clog2(NUM_DIGITS)  index of digit currently scanned
frame_tick  out  1  one-cycle pulse at end of each full scan frame

Behaviour:
- Reset (async on rst_n low): seg_out=0, dp_out=0, an_n all 1, digit_idx=0, frame_tick=0, pending/display buffers=0, pending_valid=0, counter=0, state IDLE.
- All outputs registered; they change on the same edge as the state transition that defines them.
- Decode (shared): 0..9 -> 1111110, 0110000, 1101101, 1111001, 0110011, 1011011, 1011111, 1110000, 1111111, 1111011. Codes 10..15 -> 0000000 (blank); the dp is still honoured.
- Buffering: on a load edge, pending <= {bcd_in, dp_in} and pending_valid <= 1. A later load before commit overwrites pending (last wins). Commit (display <= pending, pending_valid <= 0) happens only at a frame boundary or on IDLE->ON, so a frame is never torn. If load and commit fall on the same edge, the new bcd_in/dp_in go straight to display.
- FSM states IDLE, ON, GUARD:
  IDLE: an_n all 1, seg/dp 0. When en=1: commit if pending_valid, go to ON with idx=0 and cnt=0.
  ON: an_n[idx]=0, seg_out=decode(display[idx]), dp_out=display_dp[idx]. At cnt=DWELL_CYCLES-1: cnt=0, go to GUARD (or advance directly if GUARD_CYCLES=0).
  GUARD: an_n all 1, seg/dp 0. At cnt=GUARD_CYCLES-1, advance.
  Advance: if idx=NUM_DIGITS-1, idx=0, frame_tick=1 for one cycle, commit if pending_valid; otherwise idx+1. Then go to ON.
- en low in any state: next edge goes to IDLE, outputs blank, cnt=0, idx=0. A pending buffer is retained.
- Frame period = NUM_DIGITS*(DWELL_CYCLES+GUARD_CYCLES) cycles. Counter width is clog2 of max(DWELL,GUARD); no overflow is possible.
- At most one anode is ever low. During a reset assertion mid-scan, all anodes go high immediately (asynchronous).

Optional Feature:
LEADING_ZERO_BLANK_EN:
- Defined: digits above the highest non-zero digit of display are suppressed. Their anode stays high during their ON slot, and seg/dp are 0 unless that digit's dp bit is set. Digit 0 is always shown. Timing is unchanged.
- Undefined: all digits are shown, including leading zeros.

Decomposition:
- Package seg_pkg: 7-bit segment constants SEG_0..SEG_9 and SEG_BLANK, the FSM state enum (IDLE/ON/GUARD), and a seg_decode function.
- One sub-module, bcd_seg_decode: a combinational 4-bit in, 7-bit out decoder wrapping the package function, instantiated once.

Test Plan:
Bench parameters: NUM_DIGITS=4, DWELL=4, GUARD=2.
- Reset then en=1, load bcd_in=16'h1234 -> an_n cycles 1110,1101,1011,0111 with seg 0110011,1111001,1101101,0110000; each digit lit 4 cycles, 2 blank cycles between; frame_tick every 24 cycles.
- Load 16'h5678 mid-frame at digit 1 -> the rest of that frame still shows 1234; the new value is shown from the next frame after frame_tick.
- Load 16'h00AF with dp_in=4'b0001 -> digits 0,1 seg 0000000 with dp_out=1 on digit 0; digits 2,3 show 1111110.
- en dropped during ON of digit 2 -> next edge an_n=1111, seg=0; re-enable restarts at digit 0 after the full dwell.
- rst_n pulsed low asynchronously mid-dwell -> an_n=1111 immediately, with no clock edge; all outputs at reset values.
- LEADING_ZERO_BLANK_EN defined, load 16'h0007 -> only the digit-0 anode is ever low (1110000); the slots of digits 1..3 keep an_n all high.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed seven-segment driver: segment codes,
// scan FSM states and the BCD-to-segment decode function.
package seg_pkg;

    // Segment order is a..g with a in the MSB; 1 = segment lit.
    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ON    = 2'd1,
        GUARD = 2'd2
    } seg_state_t;

    function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
        case (bcd)
            4'd0:    seg_decode = SEG_0;
            4'd1:    seg_decode = SEG_1;
            4'd2:    seg_decode = SEG_2;
            4'd3:    seg_decode = SEG_3;
            4'd4:    seg_decode = SEG_4;
            4'd5:    seg_decode = SEG_5;
            4'd6:    seg_decode = SEG_6;
            4'd7:    seg_decode = SEG_7;
            4'd8:    seg_decode = SEG_8;
            4'd9:    seg_decode = SEG_9;
            default: seg_decode = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bcd_seg_decode.sv
// Combinational BCD digit to seven-segment pattern; non-decimal codes blank.
module bcd_seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    assign seg = seg_decode(bcd);

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with dwell/guard scan
// cadence and frame-aligned buffer commit. Define LEADING_ZERO_BLANK_EN to
// suppress leading zero digits.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 50000,
    parameter int GUARD_CYCLES = 1000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          load,
    input  logic [4*NUM_DIGITS-1:0]       bcd_in,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    output logic [6:0]                    seg_out,
    output logic                          dp_out,
    output logic [NUM_DIGITS-1:0]         an_n,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_tick
);

    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int CNT_MAX = (DWELL_CYCLES > GUARD_CYCLES) ? DWELL_CYCLES : GUARD_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    // All scan FSM state lives in this one struct so it can be probed as a unit.
    typedef struct packed {
        seg_state_t       state;
        logic [CNT_W-1:0] cnt;
        logic [IDX_W-1:0] idx;
    } scan_t;

    scan_t scan_q, scan_d;

    logic [NUM_DIGITS-1:0][3:0] pend_q, disp_q, disp_d;
    logic [NUM_DIGITS-1:0]      pend_dp_q, disp_dp_q, disp_dp_d;
    logic                       pend_valid_q;
    logic                       commit, advance, tick_d;
    logic [3:0]                 cur_bcd;
    logic [6:0]                 cur_seg;
    logic                       show;

    always_comb begin
        scan_d  = scan_q;
        commit  = 1'b0;
        advance = 1'b0;
        tick_d  = 1'b0;
        if (!en) begin
            scan_d = '{state: IDLE, cnt: '0, idx: '0};
        end else begin
            case (scan_q.state)
                IDLE: begin
                    commit = 1'b1;
                    scan_d = '{state: ON, cnt: '0, idx: '0};
                end
                ON: begin
                    if (scan_q.cnt == CNT_W'(DWELL_CYCLES - 1)) begin
                        scan_d.cnt = '0;
                        if (GUARD_CYCLES == 0) advance = 1'b1;
                        else                   scan_d.state = GUARD;
                    end else begin
                        scan_d.cnt = scan_q.cnt + 1'b1;
                    end
                end
                GUARD: begin
                    if (scan_q.cnt == CNT_W'(GUARD_CYCLES - 1)) begin
                        scan_d.cnt = '0;
                        advance    = 1'b1;
                    end else begin
                        scan_d.cnt = scan_q.cnt + 1'b1;
                    end
                end
                default: scan_d = '{state: IDLE, cnt: '0, idx: '0};
            endcase
            if (advance) begin
                scan_d.state = ON;
                if (scan_q.idx == IDX_W'(NUM_DIGITS - 1)) begin
                    scan_d.idx = '0;
                    tick_d     = 1'b1;
                    commit     = 1'b1;
                end else begin
                    scan_d.idx = scan_q.idx + 1'b1;
                end
            end
        end
    end

    // A load landing on a commit edge bypasses the pending buffer entirely.
    always_comb begin
        disp_d    = disp_q;
        disp_dp_d = disp_dp_q;
        if (commit) begin
            if (load) begin
                disp_d    = bcd_in;
                disp_dp_d = dp_in;
            end else if (pend_valid_q) begin
                disp_d    = pend_q;
                disp_dp_d = pend_dp_q;
            end
        end
    end

    assign cur_bcd = disp_d[scan_d.idx];

    bcd_seg_decode u_decode (
        .bcd (cur_bcd),
        .seg (cur_seg)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic [IDX_W-1:0] lead_idx;

    always_comb begin
        lead_idx = '0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (disp_d[i] != 4'd0) lead_idx = IDX_W'(i);
        end
    end

    assign show = (scan_d.idx <= lead_idx);
`else
    assign show = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_q       <= '{state: IDLE, cnt: '0, idx: '0};
            pend_q       <= '0;
            pend_dp_q    <= '0;
            pend_valid_q <= 1'b0;
            disp_q       <= '0;
            disp_dp_q    <= '0;
            seg_out      <= SEG_BLANK;
            dp_out       <= 1'b0;
            an_n         <= '1;
            frame_tick   <= 1'b0;
        end else begin
            scan_q     <= scan_d;
            disp_q     <= disp_d;
            disp_dp_q  <= disp_dp_d;
            frame_tick <= tick_d;
            if (load) begin
                pend_q    <= bcd_in;
                pend_dp_q <= dp_in;
            end
            if (commit)    pend_valid_q <= 1'b0;
            else if (load) pend_valid_q <= 1'b1;
            // Outputs follow the next state so they change on the defining edge.
            if (scan_d.state == ON) begin
                seg_out <= show ? cur_seg : SEG_BLANK;
                dp_out  <= disp_dp_d[scan_d.idx];
                an_n    <= show ? ~(NUM_DIGITS'(1) << scan_d.idx) : '1;
            end else begin
                seg_out <= SEG_BLANK;
                dp_out  <= 1'b0;
                an_n    <= '1;
            end
        end
    end

    assign digit_idx = scan_q.idx;

endmodule
